// File: rtl/crypt_pkg.sv
// Shared types and helpers for the LFSR keystream cipher stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: session state enum, default Galois tap mask and zero-key seed,
//           and the single-step Galois update used by RTL and reference models.
package crypt_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WARMUP = 2'd1,
      RUN    = 2'd2
   } state_t;

   // x^32 + x^22 + x^2 + x + 1
   localparam logic [31:0] TAP_MASK_DEF  = 32'h80200003;
   // An all-zero seed would lock the LFSR at zero forever.
   localparam logic [31:0] ZERO_SEED_DEF = 32'h00000001;

   // One right-shifting Galois step: feedback applied when the bit shifted out is 1.
   function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic [31:0] mask);
      return s[0] ? ((s >> 1) ^ mask) : (s >> 1);
   endfunction

endpackage

// File: rtl/galois_lfsr32.sv
// 32-bit Galois LFSR register with synchronous load and step.
// Latency: state updates on the rising edge after load/step.
// Backpressure: none; holds its value when neither load nor step is set.
// Ports: CLK, RST (async active-high) | load, seed[31:0] (load wins over step),
//        step | state[31:0] current register contents.
module galois_lfsr32
   import crypt_pkg::*;
#(
   parameter logic [31:0] TAP_MASK = TAP_MASK_DEF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        load,
   input  logic [31:0] seed,
   input  logic        step,
   output logic [31:0] state
);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= '0;
      end else if (load) begin
         state <= seed;
      end else if (step) begin
         state <= lfsr_step(state, TAP_MASK);
      end
   end

endmodule

// File: rtl/lfsr_keystream_xor.sv
// Keystream XOR stage: seeds an LFSR from key, discards WARMUP_STEPS ticks, then XORs one byte per en tick.
// Latency: 1 cycle from accept edge to dout_valid; dout holds between pulses.
// Backpressure: din_ready = en while in RUN; bytes only move on an en tick, no output stall.
// Ports: CLK, RST (async active-high) | en advance tick | start, key[31:0] session open (IDLE only)
//        | din[7:0], din_valid, din_ready | dout[7:0], dout_valid | busy (WARMUP/RUN) | stop (RUN only).
module lfsr_keystream_xor
   import crypt_pkg::*;
#(
   parameter int          WARMUP_STEPS = 16,
   parameter logic [31:0] TAP_MASK     = TAP_MASK_DEF,
   parameter logic [31:0] ZERO_SEED    = ZERO_SEED_DEF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        en,
   input  logic        start,
   input  logic [31:0] key,
   input  logic [7:0]  din,
   input  logic        din_valid,
   output logic        din_ready,
   output logic [7:0]  dout,
   output logic        dout_valid,
   output logic        busy,
   input  logic        stop
);

   // warm_cnt is 8 bits, so the warm-up length must fit in 1..255.
   generate
      if (WARMUP_STEPS < 1 || WARMUP_STEPS > 255) begin : g_bad_warmup
         $error("lfsr_keystream_xor: WARMUP_STEPS must be in 1..255");
      end
   endgenerate

   localparam logic [7:0] WARM_LAST = 8'(WARMUP_STEPS);

   state_t      st;
   logic [7:0]  warm_cnt;
   logic [31:0] lfsr_q;
   logic        lfsr_load;
   logic [31:0] lfsr_seed;
   logic        lfsr_step_en;
   logic        accept;
   logic        lfsr_dead;

   assign accept    = (st == RUN) && din_valid && en;
   assign din_ready = (st == RUN) && en;
   assign busy      = (st != IDLE);

   // Lock-up guard: a zero register can only come from an upset while busy;
   // reload the fallback seed rather than emit a constant keystream.
   assign lfsr_dead = busy && (lfsr_q == '0);

   always_comb begin
      lfsr_load    = 1'b0;
      lfsr_seed    = '0;
      lfsr_step_en = 1'b0;
      case (st)
         IDLE: begin
            lfsr_load = start;
            lfsr_seed = (key == '0) ? ZERO_SEED : key;
         end
         WARMUP: begin
            lfsr_load    = lfsr_dead;
            lfsr_seed    = ZERO_SEED;
            lfsr_step_en = en;
         end
         RUN: begin
            // stop clears the register; it also overrides a same-cycle step
            // because the session is ending anyway.
            lfsr_load    = stop || lfsr_dead;
            lfsr_seed    = stop ? '0 : ZERO_SEED;
            lfsr_step_en = accept;
         end
         default: begin
            lfsr_load = 1'b0;
         end
      endcase
   end

   galois_lfsr32 #(
      .TAP_MASK (TAP_MASK)
   ) u_lfsr (
      .CLK   (CLK),
      .RST   (RST),
      .load  (lfsr_load),
      .seed  (lfsr_seed),
      .step  (lfsr_step_en),
      .state (lfsr_q)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         st         <= IDLE;
         warm_cnt   <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         case (st)
            IDLE: begin
               if (start) begin
                  warm_cnt <= '0;
                  st       <= WARMUP;
               end
            end
            WARMUP: begin
               if (en) begin
                  warm_cnt <= warm_cnt + 8'd1;
                  if (warm_cnt + 8'd1 == WARM_LAST) begin
                     st <= RUN;
                  end
               end
            end
            RUN: begin
               // Uses the pre-step keystream byte; the LFSR advances on this same edge.
               if (accept) begin
                  dout       <= din ^ lfsr_q[7:0];
                  dout_valid <= 1'b1;
               end
               if (stop) begin
                  st <= IDLE;
               end
            end
            default: begin
               st <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/lfsr_keystream_xor.md
Name: lfsr_keystream_xor

Overview:
- Keystream encrypt/decrypt stage directly downstream of the COUNTER enable generator.
- Consumes COUNTER's `en` strobe as its advance tick.
- Seeds a 32-bit Galois LFSR from a key, runs a warm-up of discarded steps, then XORs one input byte per accepted `en` tick with the LFSR low byte.
- Encrypt and decrypt are the same operation.

Parameters:
- WARMUP_STEPS, 16, number of `en` ticks discarded after seeding; legal range 1..255.
- TAP_MASK, 32'h80200003, Galois feedback mask (x^32+x^22+x^2+x+1).
- ZERO_SEED, 32'h00000001, seed substituted when `key` is all-zero.

Ports:
- CLK  input  1  system clock; all state on rising edge.
- RST  input  1  asynchronous, active-high reset.
- en  input  1  advance strobe from COUNTER; one-cycle pulse, arbitrary spacing.
- start  input  1  begin a session; sampled only in IDLE.
- key  input  32  session seed; sampled on the accepted start.
- din  input  8  plaintext/ciphertext byte.
- din_valid  input  1  din holds a byte.
- din_ready  output  1  combinational; byte accepted this cycle when din_valid & din_ready.
- dout  output  8  registered result byte.
- dout_valid  output  1  one-cycle pulse, dout valid.
- busy  output  1  high in WARMUP or RUN.
- stop  input  1  end session; RUN -> IDLE.

Behaviour:
- Reset (async, any state):
  - state=IDLE, lfsr=0, warm_cnt=0, dout=0, dout_valid=0.
  - busy and din_ready are 0 while RST is high.
- LFSR step: if lfsr[0]==1, lfsr <= (lfsr>>1) ^ TAP_MASK; else lfsr <= lfsr>>1.
- The LFSR steps only where stated below. It never steps in IDLE.
- States:
  - IDLE: on start=1 at an edge:
    - lfsr <= (key==0 ? ZERO_SEED : key); warm_cnt <= 0; go to WARMUP.
    - `en` in the same cycle is ignored.
  - WARMUP: on each cycle with en=1, step the LFSR and increment warm_cnt.
    - When the step that makes warm_cnt==WARMUP_STEPS occurs, go to RUN on the same edge.
    - start and stop are ignored.
  - RUN:
    - din_ready = en.
    - On accept (din_valid & en): dout <= din ^ lfsr[7:0], using the pre-step LFSR; dout_valid <= 1; LFSR steps on the same edge.
    - en=1 with din_valid=0: no step, no output. The keystream is bound to bytes, not ticks.
    - stop=1: go to IDLE; lfsr is cleared to 0.
    - stop and accept in the same cycle: the accept completes (dout issued), then go to IDLE.
- din_ready is 0 in IDLE and WARMUP.
- dout_valid is high for exactly one cycle per accepted byte. Latency from accept edge to dout_valid is 1 cycle.
- dout holds its last value between pulses.
- start while busy is ignored; key changes mid-session have no effect.
- Back-to-back `en` on consecutive cycles is legal and yields consecutive accepts.
- warm_cnt is 8 bits wide. WARMUP_STEPS outside 1..255 is a parameter error; add an elaboration-time check.

Decomposition:
- Shared package crypt_pkg holds:
  - the state enum (IDLE, WARMUP, RUN);
  - the TAP_MASK and ZERO_SEED defaults;
  - a step function implementing the Galois update, reused by the bench model.
- One sub-module is natural: galois_lfsr32.
  - Inputs: CLK, RST, load, seed, step. Output: state.
  - The FSM and XOR datapath stay in the top module.

Test Plan:
- Zero-key seed: WARMUP_STEPS=1, key=0, start, one en -> lfsr==32'h80200003.
  - RUN, din=8'h00 on en -> dout=8'h03, dout_valid one cycle later.
  - Next din=8'hFF on en -> dout=8'hFD; lfsr==32'hC0300002.
- Warm-up count: default WARMUP_STEPS=16, en every 5 cycles -> busy rises after start, din_ready stays 0 until exactly 16 en pulses, then RUN.
- Byte/tick binding: in RUN, en pulses with din_valid=0 -> lfsr unchanged, no dout_valid.
  - Next accepted byte uses the same keystream byte as if the idle ticks had not occurred.
- Round trip: encrypt 8 bytes 8'h00..8'h07 with key=32'hDEADBEEF, restart with the same key, feed the ciphertext -> dout sequence equals 8'h00..8'h07.
- Simultaneous stop+accept: stop=1 with din_valid=1, en=1 -> dout_valid pulses once, state IDLE next cycle, busy=0.
  - A start in that same cycle is ignored.
- Async reset mid-RUN: assert RST between edges -> dout=0, dout_valid=0, busy=0, din_ready=0 immediately, before the next edge.
  - After release, a new start with the same key reproduces the original keystream.
